uart_tx_serializer: RTL and testbench

UART transmitter, the send-side counterpart of the receive path in the 16_2_uart design. It accepts a parallel byte through a valid/ready handshake and shifts it out on `tx` as one frame: start bit, data bits LSB first, optional parity bit, and stop bit(s). Bit timing comes from an internal divide-by-`CLK_DIV` counter, so this block and the receiver run from the same system clock and the same divisor.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_tx_serializer.sv | 150 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity codes and the
// parity helper used by both the send and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Zero-extended data leaves the XOR reduction unchanged for narrow frames.
    function automatic logic parity_bit(input logic [7:0] data, input int par);
        if (par == PAR_ODD) begin
            return ~^data;
        end else begin
            return ^data;
        end
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
        $error("uart_baud_tick: CLK_DIV out of range 2..65535");
    end

    assign tick = (cnt_q == TERM);

    // Next count: held at zero while cleared, wraps after the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: valid/ready byte intake, start/data/parity/stop framing,
// line driven from a register so it never glitches.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
        $error("uart_tx_serializer: CLK_DIV out of range 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
        $error("uart_tx_serializer: DATA_BITS out of range 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q;
    logic                 busy_q;
    logic                 tick_s;

    // The divider idles at zero so the start bit always gets a full period.
    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == ST_IDLE),
        .tick  (tick_s)
    );

    // Next-state, shift/bit-count/parity updates and the next line level.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        tx_d      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d   = ST_START;
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    par_d     = parity_bit(8'(tx_data), PARITY);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
        // Line level follows the state being entered, so it updates with it.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            ready_q   <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: four transmitter configurations checked against a
// bit-list frame model (8N1/4, 8E1/4, 8O1/4, 8N2/3).
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst_n;
    logic [3:0] valid_r;
    logic [7:0] data_r [4];
    logic [3:0] tx_w;
    logic [3:0] ready_w;
    logic [3:0] busy_w;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[0]), .tx_valid(valid_r[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]));
    uart_tx_serializer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[1]), .tx_valid(valid_r[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]));
    uart_tx_serializer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[2]), .tx_valid(valid_r[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]));
    uart_tx_serializer #(.CLK_DIV(3), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .tx_data(data_r[3]), .tx_valid(valid_r[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]));

    function automatic int cd_of(input int d);
        return (d == 3) ? 3 : 4;
    endfunction

    function automatic int par_of(input int d);
        case (d)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int sb_of(input int d);
        return (d == 3) ? 2 : 1;
    endfunction

    // Reference frame: list of bit values, each held cd_of(d) cycles.
    function automatic void build_frame(input int d, input logic [7:0] b,
                                        output logic [127:0] v, output int n);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (par_of(d) == 1) bits.push_back(~^b);
        if (par_of(d) == 2) bits.push_back(^b);
        for (int s = 0; s < sb_of(d); s++) bits.push_back(1'b1);
        v = '0;
        n = 0;
        foreach (bits[k]) begin
            for (int c = 0; c < cd_of(d); c++) begin
                v[n] = bits[k];
                n++;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Samples the line once per cycle at the falling edge, starting now.
    task automatic capture(input int d, input int n, output logic [127:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i] = tx_w[d];
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int d, input logic [7:0] b, input logic [7:0] late);
        logic [127:0] exp_v;
        logic [127:0] got_v;
        int           n;
        build_frame(d, b, exp_v, n);
        check($sformatf("ready_idle%0d", d), 128'(ready_w[d]), 128'(1'b1));
        valid_r[d] = 1'b1;
        data_r[d]  = b;
        @(negedge clk);
        check($sformatf("ready_busy_start%0d", d), 128'({ready_w[d], busy_w[d]}), 128'(2'b01));
        valid_r[d] = 1'b0;
        data_r[d]  = late;
        capture(d, n, got_v);
        check($sformatf("frame%0d_%h", d, b), got_v, exp_v);
        check($sformatf("ready_back%0d", d), 128'({ready_w[d], busy_w[d], tx_w[d]}), 128'(3'b101));
    endtask

    initial begin
        logic [127:0] e1, e2, g1, g2;
        int           n1, n2;
        logic [7:0]   rb, rb2;

        rst_n   = 1'b0;
        valid_r = 4'b0000;
        for (int d = 0; d < 4; d++) data_r[d] = 8'h00;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++)
            check($sformatf("reset%0d", d), 128'({ready_w[d], busy_w[d], tx_w[d]}), 128'(3'b101));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed single frames: 8N1 0x55, even/odd parity 0x07, 8N2 0x55.
        send_frame(0, 8'h55, 8'h55);
        send_frame(1, 8'h07, 8'h07);
        send_frame(2, 8'h07, 8'h07);
        send_frame(3, 8'h55, 8'h55);

        // Random bytes through every configuration.
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 3; k++) begin
                rb = 8'($urandom_range(0, 255));
                send_frame(d, rb, 8'($urandom_range(0, 255)));
            end
        end

        // Data changes right after accept must not reach the line.
        send_frame(0, 8'hF0, 8'h0F);

        // Back-to-back with tx_valid held: exactly one idle cycle between frames.
        for (int t = 0; t < 2; t++) begin
            int d;
            d   = (t == 0) ? 0 : 3;
            rb  = (t == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            rb2 = (t == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            build_frame(d, rb, e1, n1);
            build_frame(d, rb2, e2, n2);
            valid_r[d] = 1'b1;
            data_r[d]  = rb;
            @(negedge clk);
            data_r[d] = rb2;
            capture(d, n1 + 1, g1);
            valid_r[d] = 1'b0;
            check($sformatf("b2b_first%0d", d), g1, e1 | (128'(1) << n1));
            capture(d, n2, g2);
            check($sformatf("b2b_second%0d", d), g2, e2);
            check($sformatf("b2b_ready%0d", d), 128'({ready_w[d], busy_w[d], tx_w[d]}), 128'(3'b101));
        end

        // Reset during data bit 3 (frame cycles 17..20) aborts the frame.
        valid_r[0] = 1'b1;
        data_r[0]  = 8'h00;
        @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (17) @(negedge clk);
        check("mid_bit3_low", 128'({busy_w[0], tx_w[0]}), 128'(2'b10));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset", 128'({ready_w[0], busy_w[0], tx_w[0]}), 128'(3'b101));
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, 8'($urandom_range(0, 255)), 8'h00);

        // tx_valid is ignored while reset is held.
        rst_n      = 1'b0;
        valid_r[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("valid_in_reset", 128'({ready_w[0], busy_w[0], tx_w[0]}), 128'(3'b101));
        valid_r[0] = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        check("after_release", 128'({ready_w[0], busy_w[0], tx_w[0]}), 128'(3'b101));
        send_frame(0, 8'($urandom_range(0, 255)), 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
